// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// FSM state type and small op-classification helpers.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // True for every op that launches a multi-cycle computation.
  function automatic logic is_start(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_start = 1'b1;
      default:                              is_start = 1'b0;
    endcase
  endfunction

  // True for the divide ops, which use the longer latency.
  function automatic logic is_div(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU: is_div = 1'b1;
      default:         is_div = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: computes the pending HI/LO pair for a start op
// (product, accumulate, quotient/remainder, or hold on divide-by-zero).
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             mul_signed_s;
  logic [W2-1:0]    ext_a_s;
  logic [W2-1:0]    ext_b_s;
  logic [W2-1:0]    product_s;
  logic [W2-1:0]    acc_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] divisor_s;
  logic [WIDTH-1:0] quo_mag_s;
  logic [WIDTH-1:0] rem_mag_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;

  // Multiply: sign- or zero-extend to 2*WIDTH so one modulo product serves both.
  always_comb begin
    case (op)
      OP_MULT, OP_MADD, OP_MSUB: mul_signed_s = 1'b1;
      default:                   mul_signed_s = 1'b0;
    endcase
    if (mul_signed_s) begin
      ext_a_s = {{WIDTH{a[WIDTH-1]}}, a};
      ext_b_s = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      ext_a_s = {ZERO, a};
      ext_b_s = {ZERO, b};
    end
    product_s = ext_a_s * ext_b_s;
    acc_s     = {hi, lo};
  end

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. INT_MIN / -1 falls out as INT_MIN rem 0.
  always_comb begin
    a_neg_s   = (op == OP_DIV) && a[WIDTH-1];
    b_neg_s   = (op == OP_DIV) && b[WIDTH-1];
    mag_a_s   = a_neg_s ? (~a + ONE) : a;
    mag_b_s   = b_neg_s ? (~b + ONE) : b;
    divisor_s = (b == ZERO) ? ONE : mag_b_s;
    quo_mag_s = mag_a_s / divisor_s;
    rem_mag_s = mag_a_s % divisor_s;
    quo_s     = (a_neg_s ^ b_neg_s) ? (~quo_mag_s + ONE) : quo_mag_s;
    rem_s     = a_neg_s ? (~rem_mag_s + ONE) : rem_mag_s;
  end

  // Select the pending HI/LO; non-start ops and divide-by-zero hold HI/LO.
  always_comb begin
    case (op)
      OP_MULT, OP_MULTU:   {p_hi, p_lo} = product_s;
      OP_MADD, OP_MADDU:   {p_hi, p_lo} = acc_s + product_s;
      OP_MSUB, OP_MSUBU:   {p_hi, p_lo} = acc_s - product_s;
      OP_DIV, OP_DIVU: begin
        if (b == ZERO) begin
          {p_hi, p_lo} = {hi, lo};
        end else begin
          {p_hi, p_lo} = {rem_s, quo_s};
        end
      end
      default:             {p_hi, p_lo} = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, models the op latency
// with a down-counter and a registered busy flag for the stall unit.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  mdu_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] p_hi_r;
  logic [WIDTH-1:0] p_lo_r;
  logic [WIDTH-1:0] p_hi_s;
  logic [WIDTH-1:0] p_lo_s;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op   (op),
    .a    (a),
    .b    (b),
    .hi   (hi_r),
    .lo   (lo_r),
    .p_hi (p_hi_s),
    .p_lo (p_lo_s)
  );

  // FSM: latch the result at issue, count down the latency, commit on zero.
  // Ops arriving in RUN (including flush) are ignored; the in-flight op completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      cnt_r   <= CNT_ZERO;
      hi_r    <= ZERO;
      lo_r    <= ZERO;
      p_hi_r  <= ZERO;
      p_lo_r  <= ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!flush && is_start(op)) begin
            p_hi_r  <= p_hi_s;
            p_lo_r  <= p_lo_s;
            cnt_r   <= is_div(op) ? DIV_LOAD : MULT_LOAD;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else if (!flush && (op == OP_MTHI)) begin
            hi_r <= a;
          end else if (!flush && (op == OP_MTLO)) begin
            lo_r <= a;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_ZERO) begin
            hi_r    <= p_hi_r;
            lo_r    <= p_lo_r;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // MFHI/MFLO read port: committed HI/LO only, zero for any other op.
  always_comb begin
    case (op)
      OP_MFHI: result = hi_r;
      OP_MFLO: result = lo_r;
      default: result = ZERO;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with an expected-HI/LO scoreboard.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W    = 32;
  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic         clk;
  logic         reset;
  logic         flush;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic [W-1:0] result;

  int checks;
  int errors;
  logic [2*W-1:0] exp_q[$];

  mdu_ctrl #(.WIDTH(W), .MULT_CYCLES(MLAT), .DIV_CYCLES(DLAT), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    op = OP_MFHI; #1; h = result;
    op = OP_MFLO; #1; l = result;
    op = OP_NONE; #1;
  endtask

  // Pop the next expected HI/LO and compare against the read port.
  task automatic check_sb(input string tag);
    logic [2*W-1:0] e;
    logic [W-1:0] h, l;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      read_hilo(h, l);
      check({tag, "_hi"}, h, e[2*W-1:W]);
      check({tag, "_lo"}, l, e[W-1:0]);
    end
  endtask

  // Issue a start op, optionally flush or poke another op mid-flight, and
  // measure the busy window.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int lat, input int flush_at,
                        input int poke_at, input logic [3:0] poke_op);
    int n;
    op = o; a = x; b = y;
    @(negedge clk);
    op = OP_NONE;
    n = 0;
    while ((busy === 1'b1) && (n < lat + 20)) begin
      n++;
      flush = (n == flush_at);
      op    = (n == poke_at) ? poke_op : OP_NONE;
      a     = 32'hBAD0_BAD0;
      b     = 32'h0000_0003;
      @(negedge clk);
    end
    flush = 1'b0;
    op    = OP_NONE;
    check({tag, "_busy_cycles"}, W'(n), W'(lat));
    check_sb(tag);
  endtask

  task automatic mt(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic fl);
    op = o; a = x; flush = fl;
    @(negedge clk);
    op = OP_NONE; flush = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] h, l;
    checks = 0;
    errors = 0;
    reset = 1'b1; flush = 1'b0; op = OP_NONE; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("rst_hi", h, 32'd0);
    check("rst_lo", l, 32'd0);

    // Signed multiply; a MULT presented on the completion edge must be ignored
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, MLAT, 0, MLAT, OP_MULT);
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    op = OP_MTHI; #1;
    check("result_other_op", result, 32'd0);
    op = OP_NONE;

    // Unsigned and signed divide; an MTHI while busy must be ignored
    exp_q.push_back({32'd1, 32'd3});
    run_op("divu", OP_DIVU, 32'd7, 32'd2, DLAT, 0, 3, OP_MTHI);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DLAT, 0, 0, OP_NONE);
    exp_q.push_back({32'h0000_0000, 32'h8000_0000});
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DLAT, 0, 0, OP_NONE);

    // Divide by zero keeps HI/LO after a full busy period
    mt("mthi", OP_MTHI, 32'h12, 1'b0);
    mt("mtlo", OP_MTLO, 32'h34, 1'b0);
    exp_q.push_back({32'h12, 32'h34});
    run_op("div0", OP_DIV, 32'd9, 32'd0, DLAT, 0, 0, OP_NONE);

    // Accumulate: 10 + 3*4 = 22, then 22 - 1*23 = -1 over 64 bits
    mt("mthi0", OP_MTHI, 32'd0, 1'b0);
    mt("mtlo10", OP_MTLO, 32'd10, 1'b0);
    exp_q.push_back({32'd0, 32'd22});
    run_op("maddu", OP_MADDU, 32'd3, 32'd4, MLAT, 0, 0, OP_NONE);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    run_op("msub", OP_MSUB, 32'd1, 32'd23, MLAT, 0, 0, OP_NONE);

    // Flushed start and flushed MT are dropped
    mt("flush_mult", OP_MULT, 32'd2, 1'b1);
    @(negedge clk);
    check("flush_mult_busy2", {31'd0, busy}, 32'd0);
    mt("flush_mtlo", OP_MTLO, 32'd5, 1'b1);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check_sb("flush_hold");

    // Flush during RUN does not abort
    exp_q.push_back({32'd0, 32'd42});
    run_op("mult_flush_mid", OP_MULT, 32'd6, 32'd7, MLAT, 2, 0, OP_NONE);

    // Reset on cycle 3 of a DIV discards the pending result
    mt("mthi55", OP_MTHI, 32'h55, 1'b0);
    op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    op = OP_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("midrst_hi", h, 32'd0);
    check("midrst_lo", l, 32'd0);
    repeat (DLAT + 2) @(negedge clk);
    check("midrst_late_busy", {31'd0, busy}, 32'd0);
    read_hilo(h, l);
    check("midrst_late_hi", h, 32'd0);
    check("midrst_late_lo", l, 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
